// File: rtl/regfile_read_port.sv
// Dual-operand register file read port: one-cycle registered response with writeback
// forwarding, zero-register masking and refresh of held operands while stalled.
module regfile_read_port #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr_a,
  input  logic [ADDR_W-1:0] i_req_addr_b,
  output logic [ADDR_W-1:0] o_rf_addr_a,
  output logic [ADDR_W-1:0] o_rf_addr_b,
  input  logic [DATA_W-1:0] i_rf_data_a,
  input  logic [DATA_W-1:0] i_rf_data_b,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data_a,
  output logic [DATA_W-1:0] o_rsp_data_b
);

  localparam logic [ADDR_W-1:0] ZeroReg = ADDR_W'(NREGS - 1);

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data_a;
  logic [DATA_W-1:0] r_rsp_data_b;
  logic [ADDR_W-1:0] r_hold_addr_a;
  logic [ADDR_W-1:0] r_hold_addr_b;

  logic              w_accept;
  logic              w_fire;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_data_a_nxt;
  logic [DATA_W-1:0] w_rsp_data_b_nxt;
  logic [ADDR_W-1:0] w_hold_addr_a_nxt;
  logic [ADDR_W-1:0] w_hold_addr_b_nxt;

  assign o_req_ready  = !r_rsp_valid || i_rsp_ready;
  assign o_rf_addr_a  = i_req_addr_a;
  assign o_rf_addr_b  = i_req_addr_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data_a = r_rsp_data_a;
  assign o_rsp_data_b = r_rsp_data_b;

  assign w_accept = i_req_valid && o_req_ready;
  assign w_fire   = r_rsp_valid && i_rsp_ready;

  // Zero register beats the bypass; bypass beats the array.
  always_comb begin
    w_op_a = i_rf_data_a;
    if (i_req_addr_a == ZeroReg) begin
      w_op_a = '0;
    end else if (i_wb_en && (i_wb_addr == i_req_addr_a)) begin
      w_op_a = i_wb_data;
    end
  end

  always_comb begin
    w_op_b = i_rf_data_b;
    if (i_req_addr_b == ZeroReg) begin
      w_op_b = '0;
    end else if (i_wb_en && (i_wb_addr == i_req_addr_b)) begin
      w_op_b = i_wb_data;
    end
  end

  always_comb begin
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_a_nxt  = r_rsp_data_a;
    w_rsp_data_b_nxt  = r_rsp_data_b;
    w_hold_addr_a_nxt = r_hold_addr_a;
    w_hold_addr_b_nxt = r_hold_addr_b;
    if (w_accept) begin
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_data_a_nxt  = w_op_a;
      w_rsp_data_b_nxt  = w_op_b;
      w_hold_addr_a_nxt = i_req_addr_a;
      w_hold_addr_b_nxt = i_req_addr_b;
    end else if (r_rsp_valid) begin
      if (w_fire) begin
        w_rsp_valid_nxt = 1'b0;
      end
      // Keep held operands coherent with the array so a stalled consumer never sees stale data.
      if (i_wb_en && (i_wb_addr == r_hold_addr_a) && (r_hold_addr_a != ZeroReg)) begin
        w_rsp_data_a_nxt = i_wb_data;
      end
      if (i_wb_en && (i_wb_addr == r_hold_addr_b) && (r_hold_addr_b != ZeroReg)) begin
        w_rsp_data_b_nxt = i_wb_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_data_a  <= '0;
      r_rsp_data_b  <= '0;
      r_hold_addr_a <= '0;
      r_hold_addr_b <= '0;
    end else begin
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data_a  <= w_rsp_data_a_nxt;
      r_rsp_data_b  <= w_rsp_data_b_nxt;
      r_hold_addr_a <= w_hold_addr_a_nxt;
      r_hold_addr_b <= w_hold_addr_b_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed scenarios plus randomized traffic, checked by a
// scoreboard that resolves each response against architectural register state at consumption.
module tb_regfile_read_port;

  localparam int unsigned DataW = 64;
  localparam int unsigned NRegs = 32;
  localparam int unsigned AddrW = 5;

  logic             clk;
  logic             i_reset;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [AddrW-1:0] i_req_addr_a;
  logic [AddrW-1:0] i_req_addr_b;
  logic [AddrW-1:0] o_rf_addr_a;
  logic [AddrW-1:0] o_rf_addr_b;
  logic [DataW-1:0] i_rf_data_a;
  logic [DataW-1:0] i_rf_data_b;
  logic             i_wb_en;
  logic [AddrW-1:0] i_wb_addr;
  logic [DataW-1:0] i_wb_data;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [DataW-1:0] o_rsp_data_a;
  logic [DataW-1:0] o_rsp_data_b;

  regfile_read_port #(
    .DATA_W(DataW),
    .NREGS (NRegs),
    .ADDR_W(AddrW)
  ) u_dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr_a(i_req_addr_a),
    .i_req_addr_b(i_req_addr_b),
    .o_rf_addr_a (o_rf_addr_a),
    .o_rf_addr_b (o_rf_addr_b),
    .i_rf_data_a (i_rf_data_a),
    .i_rf_data_b (i_rf_data_b),
    .i_wb_en     (i_wb_en),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data_a(o_rsp_data_a),
    .o_rsp_data_b(o_rsp_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array: combinational read, written on the writeback strobe (register 31 included,
  // so its array contents are garbage the port must mask).
  logic [DataW-1:0] mem [NRegs];
  assign i_rf_data_a = mem[o_rf_addr_a];
  assign i_rf_data_b = mem[o_rf_addr_b];
  always @(posedge clk) if (i_wb_en) mem[i_wb_addr] <= i_wb_data;

  typedef struct {
    logic [AddrW-1:0] a;
    logic [AddrW-1:0] b;
    int unsigned      cyc;
  } req_t;

  req_t        q[$];
  int unsigned cyc;
  int          vectors;
  int          miscompares;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DataW-1:0] arch(input logic [AddrW-1:0] addr);
    return (addr == AddrW'(NRegs - 1)) ? '0 : mem[addr];
  endfunction

  task automatic check(input string name, input logic [DataW-1:0] got, input logic [DataW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: an outstanding operand pair must equal the architectural registers at consumption.
  always @(negedge clk) begin
    if (!i_reset) begin
      q.delete();
    end else if (o_rsp_valid) begin
      if (q.size() == 0 || q[0].cyc >= cyc) begin
        check("unexpected_rsp_valid", 64'(o_rsp_valid), 64'd0);
      end else begin
        check("rsp_a", o_rsp_data_a, arch(q[0].a));
        check("rsp_b", o_rsp_data_b, arch(q[0].b));
        if (i_rsp_ready) void'(q.pop_front());
      end
    end else if (q.size() != 0 && q[0].cyc < cyc) begin
      check("missing_rsp_valid", 64'(o_rsp_valid), 64'd1);
      void'(q.pop_front());
    end
  end

  // One clock of stimulus; records an accept for the edge about to happen.
  task automatic step();
    @(negedge clk);
    if (i_reset && i_req_valid && o_req_ready) begin
      q.push_back('{a: i_req_addr_a, b: i_req_addr_b, cyc: cyc});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AddrW-1:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 2) return AddrW'(NRegs - 1);
    if (r < 6) return AddrW'($urandom_range(0, 3));
    return AddrW'($urandom_range(0, NRegs - 1));
  endfunction

  task automatic req(input logic [AddrW-1:0] a, input logic [AddrW-1:0] b);
    i_req_valid  = 1'b1;
    i_req_addr_a = a;
    i_req_addr_b = b;
  endtask

  task automatic wb(input logic en, input logic [AddrW-1:0] addr, input logic [DataW-1:0] data);
    i_wb_en   = en;
    i_wb_addr = addr;
    i_wb_data = data;
  endtask

  initial begin
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < int'(NRegs); i++) mem[i] = {$urandom, $urandom};
    i_reset     = 1'b0;
    i_rsp_ready = 1'b1;
    req(5'd3, 5'd7);
    wb(1'b0, '0, '0);
    @(posedge clk);
    #1;

    // Reset held with a request pending: nothing accepted.
    step();
    step();
    check("reset_valid", 64'(o_rsp_valid), 64'd0);
    check("reset_data_a", o_rsp_data_a, 64'd0);
    check("reset_data_b", o_rsp_data_b, 64'd0);
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    step();
    check("post_reset_idle", 64'(o_rsp_valid), 64'd0);

    // Basic read and back-to-back streaming.
    mem[3] = 64'h11;
    mem[7] = 64'h22;
    req(5'd3, 5'd7);
    step();
    check("basic_valid", 64'(o_rsp_valid), 64'd1);
    check("basic_a", o_rsp_data_a, 64'h11);
    check("basic_b", o_rsp_data_b, 64'h22);
    req(5'd7, 5'd3);
    step();
    check("stream_a", o_rsp_data_a, 64'h22);
    check("stream_b", o_rsp_data_b, 64'h11);
    i_req_valid = 1'b0;
    step();
    check("drain_valid", 64'(o_rsp_valid), 64'd0);

    // Same-cycle bypass and zero register.
    mem[5] = 64'h0;
    req(5'd5, 5'd31);
    wb(1'b1, 5'd5, 64'hDEAD);
    step();
    check("bypass_a", o_rsp_data_a, 64'hDEAD);
    check("xzr_b", o_rsp_data_b, 64'h0);
    wb(1'b1, 5'd31, 64'hBEEF);
    step();
    check("xzr_fwd_b", o_rsp_data_b, 64'h0);
    check("xzr_fwd_a", o_rsp_data_a, 64'hDEAD);
    wb(1'b0, '0, '0);

    // Stall refresh.
    req(5'd9, 5'd2);
    step();
    i_rsp_ready = 1'b0;
    req(5'd1, 5'd1);
    wb(1'b1, 5'd9, 64'h55);
    #1;
    check("stall_req_ready", 64'(o_req_ready), 64'd0);
    step();
    wb(1'b0, '0, '0);
    check("refresh_a", o_rsp_data_a, 64'h55);
    check("refresh_valid", 64'(o_rsp_valid), 64'd1);
    i_rsp_ready = 1'b1;
    step();
    check("release_a", o_rsp_data_a, arch(5'd1));

    // Accept beats refresh in the same cycle.
    req(5'd9, 5'd9);
    step();
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    step();
    i_rsp_ready = 1'b1;
    req(5'd4, 5'd6);
    wb(1'b1, 5'd9, 64'h77);
    step();
    wb(1'b0, '0, '0);
    check("accept_wins_a", o_rsp_data_a, arch(5'd4));
    check("accept_wins_b", o_rsp_data_b, arch(5'd6));

    // Reset during a stalled response.
    i_rsp_ready = 1'b0;
    req(5'd8, 5'd10);
    step();
    i_reset = 1'b0;
    step();
    check("stall_reset_valid", 64'(o_rsp_valid), 64'd0);
    check("stall_reset_data", o_rsp_data_a | o_rsp_data_b, 64'd0);
    i_reset = 1'b1;
    i_rsp_ready = 1'b1;
    req(5'd3, 5'd7);
    step();
    check("after_reset_a", o_rsp_data_a, 64'h11);
    check("after_reset_b", o_rsp_data_b, 64'h22);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      i_reset      = ($urandom_range(0, 99) != 0);
      i_req_valid  = ($urandom_range(0, 3) != 0);
      i_req_addr_a = pick_addr();
      i_req_addr_b = ($urandom_range(0, 7) == 0) ? i_req_addr_a : pick_addr();
      i_rsp_ready  = ($urandom_range(0, 9) < 6);
      wb($urandom_range(0, 1) == 1, pick_addr(), {$urandom, $urandom});
      step();
    end

    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    wb(1'b0, '0, '0);
    step();
    step();
    step();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
